tx_rx_link: RTL and testbench

//   Parametrised single-clock successor to the fixed 8-bit TX/RX pair and free-running synthesizer.
//   - RX side: accepts words on an enable strobe into a DEPTH-entry FIFO.
//   - TX side: presents words with a valid/ready handshake.
//   - Programmable-divide wave generator runs only while TX has data.
//   - Sits between the upstream data source and the transmit/synth stage of the link top level.

---
 rtl/tx_rx_link.sv | 129 ++++++++++++
 tb/tb_tx_rx_link.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_rx_link.sv
// tx_rx_link: RX strobe into a FWFT FIFO, valid/ready TX side, and a divided
// wave generator that runs only while TX holds data.
// Ports: clk, rst (sync, active-high), en_rx/in_data/in_ready (RX),
// out_data/out_valid/out_ready (TX), div_ratio/wave (synth),
// level (occupancy), overflow (sticky drop flag).
// Optional macro TX_RX_LINK_PARITY_EN stores even parity per word and adds
// the out_parity output.
module tx_rx_link #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int DIV_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_rx,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic [DIV_W-1:0]       div_ratio,
  output logic                   wave,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
`ifdef TX_RX_LINK_PARITY_EN
  ,
  output logic                   out_parity
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef TX_RX_LINK_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  logic [MW-1:0]    mem [DEPTH];
  logic [MW-1:0]    wr_word;
  logic [MW-1:0]    head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push;
  logic             pop;
  state_t           state;
  logic [DIV_W-1:0] div_cnt;

`ifdef TX_RX_LINK_PARITY_EN
  assign wr_word = {^in_data, in_data};
`else
  assign wr_word = in_data;
`endif

  assign in_ready  = (count != LW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = en_rx & in_ready;
  assign pop       = out_valid & out_ready;
  assign level     = count;
  assign head      = mem[rd_ptr];

  // Gate the head word so an empty FIFO never shows stale or unknown data.
  assign out_data = out_valid ? head[DATA_W-1:0] : '0;
`ifdef TX_RX_LINK_PARITY_EN
  assign out_parity = out_valid & head[DATA_W];
`endif

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
      // Full means no accept, even when the head leaves this cycle.
      if (en_rx && !in_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      wave    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          div_cnt <= '0;
          wave    <= 1'b0;
          if (out_valid) state <= RUN;
        end
        RUN: begin
          if (!out_valid) begin
            state   <= IDLE;
            div_cnt <= '0;
            wave    <= 1'b0;
          end else if (div_cnt >= div_ratio) begin
            // >= so a lowered div_ratio takes effect at once.
            div_cnt <= '0;
            wave    <= ~wave;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_rx_link.sv
// tb_tx_rx_link: vector table, wave sequence and randomized run
// against a queue-based reference model of tx_rx_link.
module tb_tx_rx_link;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_rx;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] div_ratio;
  logic       wave;
  logic [2:0] level;
  logic       overflow;
`ifdef TX_RX_LINK_PARITY_EN
  logic       out_parity;
`endif

  tx_rx_link #(.DATA_W(8), .DEPTH(4), .DIV_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_rx     (en_rx),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .div_ratio (div_ratio),
    .wave      (wave),
    .level     (level),
    .overflow  (overflow)
`ifdef TX_RX_LINK_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  name, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic e,
                      input logic [7:0] d, input logic o);
    rst       = r;
    en_rx     = e;
    in_data   = d;
    out_ready = o;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [7:0] d;
    logic       o;
    logic [2:0] lvl;
    logic       vld;
    logic [7:0] dat;
    logic       rdy;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic r, input logic e, input logic [7:0] d,
                   input logic o, input logic [2:0] lvl, input logic vld,
                   input logic [7:0] dat, input logic rdy, input logic ovf);
    vec_t t;
    t.r = r; t.e = e; t.d = d; t.o = o;
    t.lvl = lvl; t.vld = vld; t.dat = dat; t.rdy = rdy; t.ovf = ovf;
    tbl.push_back(t);
  endtask

  // Reference model state.
  logic [7:0] mq[$];
  logic       m_ovf;
  logic       m_run;
  int         m_phase;
  logic       m_wave;

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_run   = 1'b0;
    m_phase = 0;
    m_wave  = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic e,
                            input logic [7:0] d, input logic o,
                            input int div);
    bit had;
    if (r) begin
      model_reset();
      return;
    end
    had = (mq.size() != 0);
    if (!m_run) begin
      m_phase = 0;
      m_wave  = 1'b0;
      if (had) m_run = 1'b1;
    end else if (!had) begin
      m_run   = 1'b0;
      m_phase = 0;
      m_wave  = 1'b0;
    end else if (m_phase >= div) begin
      m_phase = 0;
      m_wave  = ~m_wave;
    end else begin
      m_phase++;
    end
    if (e && mq.size() == 4) m_ovf = 1'b1;
    if (e && mq.size() < 4) begin
      if (had && o) void'(mq.pop_front());
      mq.push_back(d);
    end else if (had && o) begin
      void'(mq.pop_front());
    end
  endtask

  logic [7:0] wexp [18];

  initial begin
    rst = 1'b1; en_rx = 1'b0; in_data = '0; out_ready = 1'b0;
    div_ratio = 4'hF;

    // Reset, mid-stream reset, fill/overflow, drain, streaming, full+pop.
    v(1,0,8'h00,0, 0,0,8'h00,1,0);
    v(1,0,8'h00,0, 0,0,8'h00,1,0);
    v(0,1,8'hA1,0, 1,1,8'hA1,1,0);
    v(0,1,8'hB2,0, 2,1,8'hA1,1,0);
    v(0,1,8'hC3,0, 3,1,8'hA1,1,0);
    v(1,1,8'hEE,0, 0,0,8'h00,1,0);
    v(1,0,8'h00,0, 0,0,8'h00,1,0);
    v(0,1,8'hA1,0, 1,1,8'hA1,1,0);
    v(0,1,8'hB2,0, 2,1,8'hA1,1,0);
    v(0,1,8'hC3,0, 3,1,8'hA1,1,0);
    v(0,1,8'hD4,0, 4,1,8'hA1,0,0);
    v(0,1,8'h55,0, 4,1,8'hA1,0,1);
    v(0,0,8'h00,1, 3,1,8'hB2,1,1);
    v(0,0,8'h00,1, 2,1,8'hC3,1,1);
    v(0,0,8'h00,1, 1,1,8'hD4,1,1);
    v(0,0,8'h00,1, 0,0,8'h00,1,1);
    v(0,1,8'h10,0, 1,1,8'h10,1,1);
    v(0,1,8'h11,0, 2,1,8'h10,1,1);
    v(0,1,8'h12,1, 2,1,8'h11,1,1);
    v(0,1,8'h13,1, 2,1,8'h12,1,1);
    v(0,1,8'h14,1, 2,1,8'h13,1,1);
    v(0,1,8'h15,1, 2,1,8'h14,1,1);
    v(0,1,8'h16,1, 2,1,8'h15,1,1);
    v(0,1,8'h17,1, 2,1,8'h16,1,1);
    v(0,0,8'h00,1, 1,1,8'h17,1,1);
    v(0,0,8'h00,1, 0,0,8'h00,1,1);
    v(0,1,8'h20,0, 1,1,8'h20,1,1);
    v(0,1,8'h21,0, 2,1,8'h20,1,1);
    v(0,1,8'h22,0, 3,1,8'h20,1,1);
    v(0,1,8'h23,0, 4,1,8'h20,0,1);
    v(0,1,8'h24,1, 3,1,8'h21,1,1);
    v(1,0,8'h00,0, 0,0,8'h00,1,0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].o);
      chk($sformatf("tbl%0d level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d valid", i), 32'(out_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      if (tbl[i].vld)
        chk($sformatf("tbl%0d data", i), 32'(out_data), 32'(tbl[i].dat));
      if (tbl[i].r)
        chk($sformatf("tbl%0d wave", i), 32'(wave), 32'(0));
    end

    // Wave: div 3 -> toggle every 4 run cycles; drop to 1 mid-count.
    wexp = '{0,0,0,0,0,1,1,1,1,0,0,1,1,0,0,1,1,0};
    div_ratio = 4'd3;
    step(1, 0, 8'h00, 0);
    for (int k = 0; k < 16; k++) begin
      if (k == 11) div_ratio = 4'd1;
      step(0, k == 0, 8'h5A, 0);
      chk($sformatf("wave e%0d", k), 32'(wave), 32'(wexp[k]));
    end
    step(0, 0, 8'h00, 1);
    chk("wave e16", 32'(wave), 32'(wexp[16]));
    step(0, 0, 8'h00, 0);
    chk("wave e17 idle", 32'(wave), 32'(wexp[17]));
    chk("wave e17 valid", 32'(out_valid), 32'(0));

`ifdef TX_RX_LINK_PARITY_EN
    step(1, 0, 8'h00, 0);
    chk("par empty", 32'(out_parity), 32'(0));
    step(0, 1, 8'h07, 0);
    step(0, 1, 8'h03, 0);
    chk("par 07", 32'(out_parity), 32'(1));
    step(0, 0, 8'h00, 1);
    chk("par 03", 32'(out_parity), 32'(0));
`endif

    // Randomized run against the reference model.
    step(1, 0, 8'h00, 0);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic       r, e, o;
      logic [7:0] d;
      r = ($urandom_range(0, 149) == 0);
      e = ($urandom_range(0, 99) < ((c / 500) % 2 ? 70 : 40));
      o = ($urandom_range(0, 99) < ((c / 500) % 2 ? 35 : 60));
      d = 8'($urandom);
      if ($urandom_range(0, 29) == 0) div_ratio = 4'($urandom_range(0, 4));
      model_step(r, e, d, o, int'(div_ratio));
      step(r, e, d, o);
      chk("rnd level", 32'(level), 32'(mq.size()));
      chk("rnd valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("rnd ready", 32'(in_ready), 32'(mq.size() != 4));
      chk("rnd ovf", 32'(overflow), 32'(m_ovf));
      chk("rnd wave", 32'(wave), 32'(m_wave));
      if (mq.size() != 0) chk("rnd data", 32'(out_data), 32'(mq[0]));
`ifdef TX_RX_LINK_PARITY_EN
      chk("rnd parity", 32'(out_parity),
          32'(mq.size() != 0 ? ^mq[0] : 1'b0));
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
